mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle MIPS control FSM: the producer side of the ALU's 3-bit ALUcontrol code
//  and of every datapath select/enable. Decodes opcode/funct latched in the IR.
//  Sequences fetch/decode/execute/memory/writeback. Consumes the ALU Z flag for branches.
//  Sits between the instruction register and the datapath muxes, register file and memory.
// PARAMETERS
//  (none; encodings below are fixed)
// PORTS
//  clk          in   1  rising-edge clock, single domain
//  rst          in   1  synchronous, active-high reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU Z (1 = result 0), sampled in BRANCH
//  pc_en        out  1  PC load enable (unconditional or branch-taken)
//  iord         out  1  mem addr select: 0=PC, 1=ALUOut
//  mem_write    out  1  data memory write strobe
//  ir_write     out  1  IR load enable
//  reg_dst      out  1  write reg: 0=rt, 1=rd
//  mem_to_reg   out  1  writeback data: 0=ALUOut, 1=MDR
//  reg_write    out  1  register file write enable
//  alu_src_a    out  1  0=PC, 1=rs
//  alu_src_b    out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  imm_zext     out  1  1 = zero-extend imm (andi/ori/xori) in alu_src_b=10
//  pc_src       out  2  00=ALU result, 01=ALUOut, 10=jump target
//  alu_control  out  3  000 add,001 sub,010 and,011 or,100 xor,101 nor,110 slt,111 sltu
//  illegal      out  1  one-cycle pulse: unsupported opcode/funct seen in DECODE
//  state        out  4  current FSM state, for debug
// BEHAVIOUR
//  Synchronous, active-high reset: state<=FETCH. All outputs Moore (from state + IR) except pc_en in BRANCH.
//  Default every strobe 0, selects 0, alu_control=000 unless listed.
//  States (4-bit encoding):
//   0 FETCH : iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, add, pc_src=00, pc_en=1 -> DECODE
//   1 DECODE: alu_src_a=0, alu_src_b=11, add (branch target to ALUOut). Next by opcode:
//     000000 R -> EXEC_R; 100011 lw / 101011 sw -> MEMADR; 000100 beq / 000101 bne -> BRANCH;
//     001000 addi, 001100 andi, 001101 ori, 001110 xori, 001010 slti, 001011 sltiu -> EXEC_I;
//     000010 j -> JUMP; any other opcode, or R-type with unsupported funct -> FETCH + illegal=1
//   2 MEMADR: alu_src_a=1, alu_src_b=10, add -> MEMRD (lw) / MEMWR (sw)
//   3 MEMRD : iord=1 -> MEMWB
//   4 MEMWB : reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH
//   5 MEMWR : iord=1, mem_write=1 -> FETCH
//   6 EXEC_R: alu_src_a=1, alu_src_b=00, alu_control from funct:
//     100000 000, 100010 001, 100100 010, 100101 011, 100110 100, 100111 101, 101010 110, 101011 111 -> WB_R
//   7 WB_R  : reg_dst=1, reg_write=1, alu_control held as EXEC_R -> FETCH
//   8 BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01;
//     pc_en = zero (beq) or ~zero (bne), combinational in this cycle -> FETCH
//   9 EXEC_I: alu_src_a=1, alu_src_b=10; add/and/or/xor/slt/sltu per opcode; imm_zext=1 for andi/ori/xori -> WB_I
//  10 WB_I  : reg_dst=0, reg_write=1, selects held as EXEC_I -> FETCH
//  11 JUMP  : pc_src=10, pc_en=1 -> FETCH
//   Unused state codes 12-15 -> FETCH next cycle, all strobes 0.
//  CPI: lw 5, sw/R/I-type 4, beq/bne/j 3, illegal 2.
//  rst asserted in any state: next edge FETCH, no write strobe (mem_write/reg_write/pc_en) in that cycle's output beyond the combinational value of the current state; strobes are 0 from the cycle after.
//  opcode/funct changes outside DECODE/EXEC/WB are ignored (IR stable by contract).
// TESTING
//  rst=1 two cycles, release -> state=0, ir_write=1, pc_en=1, alu_src_b=01, alu_control=000
//  opcode=000000, funct=100111 (nor) -> states 0,1,6,7,0; alu_control=101 in 6 and 7; reg_write+reg_dst=1 only in 7
//  opcode=100011 (lw) -> states 0,1,2,3,4,0; iord=1 in 3; reg_write=1, mem_to_reg=1 in 4
//  opcode=000100 beq: zero=1 -> pc_en=1 in BRANCH; zero=0 -> pc_en=0; repeat bne -> inverted; alu_control=001
//  opcode=001101 ori -> state 9 with alu_control=011, imm_zext=1; state 10 reg_write=1, reg_dst=0
//  opcode=111111 -> illegal=1 for exactly one cycle in DECODE, then FETCH; rst asserted in MEMWR -> FETCH next edge

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Signal bundle between the multicycle MIPS controller and its datapath.
// There is no valid/ready handshake on this bus: opcode/funct come straight
// from the IR and are stable from DECODE onward; every control output is a
// level that the datapath samples on the next rising clock edge.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       illegal;
    logic [3:0] state;

    // Controller side: consumes IR fields and ALU Z, drives all selects/enables.
    modport master (
        input  opcode, funct, zero,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
        output alu_src_a, alu_src_b, imm_zext, pc_src, alu_control, illegal, state
    );

    // Datapath side: supplies IR fields and ALU Z, obeys the controls.
    modport slave (
        output opcode, funct, zero,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
        input  alu_src_a, alu_src_b, imm_zext, pc_src, alu_control, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Sequences fetch/decode/execute/memory/writeback,
// decodes opcode/funct from the IR and drives every datapath select and enable.
// Outputs are Moore (state + stable IR) except pc_en in BRANCH, which follows zero.
module mips_multicycle_ctrl (
    input  logic                          clk,
    input  logic                          rst,
    mips_multicycle_ctrl_if.master        bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_WB_R   = 4'd7,
        S_BRANCH = 4'd8,
        S_EXEC_I = 4'd9,
        S_WB_I   = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    state_t state_q;

    // R-type funct decode: {supported, alu_control}
    function automatic logic [3:0] r_decode(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b1_000;
            6'b100010: return 4'b1_001;
            6'b100100: return 4'b1_010;
            6'b100101: return 4'b1_011;
            6'b100110: return 4'b1_100;
            6'b100111: return 4'b1_101;
            6'b101010: return 4'b1_110;
            6'b101011: return 4'b1_111;
            default:   return 4'b0_000;
        endcase
    endfunction

    // I-type ALU opcode decode: {supported, imm_zext, alu_control}
    function automatic logic [4:0] i_decode(input logic [5:0] op);
        case (op)
            6'b001000: return 5'b1_0_000;
            6'b001100: return 5'b1_1_010;
            6'b001101: return 5'b1_1_011;
            6'b001110: return 5'b1_1_100;
            6'b001010: return 5'b1_0_110;
            6'b001011: return 5'b1_0_111;
            default:   return 5'b0_0_000;
        endcase
    endfunction

    logic [3:0] r_dec;
    logic [4:0] i_dec;
    logic       r_ok;
    logic       i_ok;
    logic       op_legal;

    assign r_dec    = r_decode(bus.funct);
    assign i_dec    = i_decode(bus.opcode);
    assign r_ok     = (bus.opcode == OP_R) && r_dec[3];
    assign i_ok     = i_dec[4];
    assign op_legal = r_ok || i_ok ||
                      (bus.opcode == OP_LW)  || (bus.opcode == OP_SW) ||
                      (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE) ||
                      (bus.opcode == OP_J);

    // State register and next-state sequencing; unknown codes fall back to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    if (r_ok)                                                  state_q <= S_EXEC_R;
                    else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW))   state_q <= S_MEMADR;
                    else if ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)) state_q <= S_BRANCH;
                    else if (i_ok)                                             state_q <= S_EXEC_I;
                    else if (bus.opcode == OP_J)                               state_q <= S_JUMP;
                    else                                                       state_q <= S_FETCH;
                end
                S_MEMADR: state_q <= (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_q <= S_MEMWB;
                S_EXEC_R: state_q <= S_WB_R;
                S_EXEC_I: state_q <= S_WB_I;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Moore control decode from state and IR; pc_en in BRANCH follows zero.
    always_comb begin
        bus.pc_en       = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.imm_zext    = 1'b0;
        bus.pc_src      = 2'b00;
        bus.alu_control = ALU_ADD;
        bus.illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ir_write  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.pc_en     = 1'b1;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                bus.illegal   = ~op_legal;
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = r_dec[2:0];
            end
            S_WB_R: begin
                bus.reg_dst     = 1'b1;
                bus.reg_write   = 1'b1;
                bus.alu_control = r_dec[2:0];
            end
            S_BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = ALU_SUB;
                bus.pc_src      = 2'b01;
                bus.pc_en       = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
            end
            S_EXEC_I: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.imm_zext    = i_dec[3];
                bus.alu_control = i_dec[2:0];
            end
            S_WB_I: begin
                bus.reg_write   = 1'b1;
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.imm_zext    = i_dec[3];
                bus.alu_control = i_dec[2:0];
            end
            S_JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: directed instructions from the spec's
// test list followed by random instructions, each expanded by a reference model
// into the per-cycle control vectors it must produce.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] pc_src;
        logic [2:0] alu;
        logic       illegal;
    } rec_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    rec_t exp_q[$];

    // Instruction tables: position in r_functs is the ALU code.
    logic [5:0] r_functs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    logic [5:0] i_ops    [6] = '{6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b};
    logic [2:0] i_alu    [6] = '{3'd0,  3'd2,  3'd3,  3'd4,  3'd6,  3'd7};
    logic       i_zext   [6] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
    logic [5:0] legal_ops[12] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08,
                                  6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b, 6'h02};

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t blank(input int st);
        rec_t r;
        r    = '0;
        r.st = st[3:0];
        return r;
    endfunction

    // Reference model: per-cycle control vectors for one instruction.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        rec_t r;
        int   ri;
        int   ii;
        logic legal;
        ri = -1;
        ii = -1;
        for (int k = 0; k < 8; k++) if (op == 6'h00 && fn == r_functs[k]) ri = k;
        for (int k = 0; k < 6; k++) if (op == i_ops[k]) ii = k;
        legal = (ri >= 0) || (ii >= 0) || op == 6'h23 || op == 6'h2b ||
                op == 6'h04 || op == 6'h05 || op == 6'h02;

        r = blank(0); r.ir_write = 1; r.alu_src_b = 2'b01; r.pc_en = 1; exp_q.push_back(r);
        r = blank(1); r.alu_src_b = 2'b11; r.illegal = ~legal;            exp_q.push_back(r);
        if (!legal) return;

        if (ri >= 0) begin
            r = blank(6); r.alu_src_a = 1; r.alu = ri[2:0];                  exp_q.push_back(r);
            r = blank(7); r.reg_dst = 1; r.reg_write = 1; r.alu = ri[2:0];  exp_q.push_back(r);
        end else if (op == 6'h23 || op == 6'h2b) begin
            r = blank(2); r.alu_src_a = 1; r.alu_src_b = 2'b10; exp_q.push_back(r);
            if (op == 6'h23) begin
                r = blank(3); r.iord = 1;                        exp_q.push_back(r);
                r = blank(4); r.mem_to_reg = 1; r.reg_write = 1; exp_q.push_back(r);
            end else begin
                r = blank(5); r.iord = 1; r.mem_write = 1;       exp_q.push_back(r);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            r = blank(8); r.alu_src_a = 1; r.alu = 3'd1; r.pc_src = 2'b01;
            r.pc_en = (op == 6'h04) ? z : ~z;
            exp_q.push_back(r);
        end else if (ii >= 0) begin
            r = blank(9); r.alu_src_a = 1; r.alu_src_b = 2'b10;
            r.alu = i_alu[ii]; r.imm_zext = i_zext[ii];
            exp_q.push_back(r);
            r.st = 4'd10; r.reg_write = 1;
            exp_q.push_back(r);
        end else begin
            r = blank(11); r.pc_src = 2'b10; r.pc_en = 1; exp_q.push_back(r);
        end
    endtask

    // Scoreboard comparison of the live control vector against one expectation.
    task automatic check_rec(input string tag, input rec_t e);
        rec_t o;
        o = '{bus.state, bus.pc_en, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
              bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.imm_zext,
              bus.pc_src, bus.alu_control, bus.illegal};
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%h required=%h (st %0d vs %0d)", tag, o, e, o.st, e.st);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: start in FETCH, apply the IR fields, walk every expected cycle.
    // cut >= 0 asserts rst right after that step and expects FETCH next edge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int cut);
        int   step;
        rec_t e;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        model_instr(op, fn, z);
        step = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_rec($sformatf("op%02h_fn%02h_z%0d_step%0d", op, fn, z, step), e);
            if (step == cut) begin
                exp_q.delete();
                rst = 1'b1;
                tick();
                check_rec($sformatf("rst_after_op%02h_step%0d", op, step), blank_fetch());
                rst = 1'b0;
                return;
            end
            step++;
            tick();
        end
    endtask

    function automatic rec_t blank_fetch();
        rec_t r;
        r = blank(0); r.ir_write = 1; r.alu_src_b = 2'b01; r.pc_en = 1;
        return r;
    endfunction

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         cut;
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;

        // Reset two cycles, then release: FETCH controls.
        repeat (2) tick();
        check_rec("reset_fetch", blank_fetch());
        rst = 1'b0;

        // Directed steps.
        run_instr(6'h00, 6'h27, 1'b0, -1);  // nor
        run_instr(6'h23, 6'h00, 1'b0, -1);  // lw
        run_instr(6'h2b, 6'h00, 1'b0, -1);  // sw
        run_instr(6'h04, 6'h00, 1'b1, -1);  // beq taken
        run_instr(6'h04, 6'h00, 1'b0, -1);  // beq not taken
        run_instr(6'h05, 6'h00, 1'b1, -1);  // bne not taken
        run_instr(6'h05, 6'h00, 1'b0, -1);  // bne taken
        run_instr(6'h0d, 6'h3f, 1'b0, -1);  // ori
        run_instr(6'h02, 6'h00, 1'b0, -1);  // j
        run_instr(6'h3f, 6'h00, 1'b0, -1);  // illegal opcode
        run_instr(6'h00, 6'h01, 1'b0, -1);  // illegal R funct
        run_instr(6'h2b, 6'h00, 1'b0, 3);   // reset while in MEMWR
        run_instr(6'h00, 6'h20, 1'b0, 2);   // reset while in EXEC_R
        run_instr(6'h23, 6'h00, 1'b0, 4);   // reset while in MEMWB
        run_instr(6'h0b, 6'h00, 1'b0, -1);  // sltiu after resets

        // Random instructions.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
            else                            op = legal_ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 3) == 0)  fn = 6'($urandom_range(0, 63));
            else                            fn = r_functs[$urandom_range(0, 7)];
            cut = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, fn, 1'($urandom_range(0, 1)), cut);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
